// File: rtl/vga_pkg.sv
// Shared constants, control-state encoding and row-address helper for the
// VGA frame-buffer arbiter.
package vga_pkg;

    // 640x480@60 timing totals and active area
    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 525;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    // Frame buffer is the active area halved in both directions
    localparam int FB_W     = H_ACTIVE / 2;
    localparam int FB_H     = V_ACTIVE / 2;
    localparam int FB_WORDS = FB_W * FB_H;
    localparam int ADDR_W   = 17;
    localparam int DATA_W   = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } ctrl_state_t;

    // row * 320 as (row << 8) + (row << 6); keeps the scan path multiplier-free
    function automatic logic [16:0] row_base(input logic [7:0] row);
        logic [16:0] r;
        r = {9'd0, row};
        return (r << 8) + (r << 6);
    endfunction

endpackage

// File: rtl/vga_wr_fifo.sv
// Small synchronous FIFO buffering host writes: valid/ready on the push
// side, a pop strobe on the read side, and empty/full flags.
module vga_wr_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty      = (count_q == {CNT_W{1'b0}});
    assign full       = (count_q == FULL_CNT);
    assign push_ready = !full;
    assign head_data  = mem_q[rd_ptr_q];

    // A push while full is refused even if a pop frees a slot this cycle
    assign do_push_s = push_valid && !full;
    assign do_pop_s  = pop && !empty;

    // Next-state for storage, pointers (wrapping naturally) and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers; reset discards every queued entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/vga_vram_arbiter.sv
// Single-port video RAM arbiter: display scan-out beats the frame-clear
// engine, which beats queued host writes. Produces the doubled pixel stream.
module vga_vram_arbiter #(
    parameter int ADDR_W     = vga_pkg::ADDR_W,
    parameter int DATA_W     = vga_pkg::DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int FB_W       = vga_pkg::FB_W,
    parameter int FB_WORDS   = vga_pkg::FB_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_tick,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    input  logic              video_on,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    input  logic              clear_start,
    input  logic [DATA_W-1:0] clear_color,
    output logic              clear_busy,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] rgb
);

    import vga_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FB_WORDS - 1);
    localparam logic [9:0]        X_LAST_RD  = 10'(2 * FB_W - 1);
    localparam logic [9:0]        X_LINE_END = 10'(H_TOTAL - 1);
    localparam logic [9:0]        Y_FRAME_END = 10'(V_TOTAL - 1);
    localparam logic [8:0]        ROW_LIMIT  = 9'(FB_H);

    ctrl_state_t       state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [DATA_W-1:0] clr_color_q, clr_color_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] fetch_q, fetch_d;
    logic [DATA_W-1:0] rgb_q, rgb_d;

    logic              disp_req_s;
    logic [ADDR_W-1:0] disp_addr_s;
    logic [9:0]        x_plus1_s;
    logic [9:0]        ny_s;
    logic              fifo_push_s;
    logic              fifo_ready_s;
    logic              fifo_pop_s;
    logic              fifo_empty_s;
    logic              fifo_full_s;
    logic [ADDR_W+DATA_W-1:0] fifo_head_s;
    logic [ADDR_W-1:0] head_addr_s;
    logic [DATA_W-1:0] head_data_s;

    assign clear_busy  = (state_q == ST_CLEAR);
    assign host_ready  = fifo_ready_s && !clear_busy;
    assign fifo_push_s = host_valid && !clear_busy;
    assign head_addr_s = fifo_head_s[ADDR_W+DATA_W-1:DATA_W];
    assign head_data_s = fifo_head_s[DATA_W-1:0];

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign rgb       = rgb_q;

    vga_wr_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (fifo_push_s),
        .push_ready (fifo_ready_s),
        .push_data  ({host_addr, host_data}),
        .pop        (fifo_pop_s),
        .head_data  (fifo_head_s),
        .empty      (fifo_empty_s),
        .full       (fifo_full_s)
    );

    // Next column pair and next line (wrapping at frame end) for prefetch
    assign x_plus1_s = pixel_x + 10'd1;
    assign ny_s      = (pixel_y == Y_FRAME_END) ? 10'd0 : (pixel_y + 10'd1);

    // Display fetch: on odd x prefetch the word for the next pixel pair,
    // at line end prefetch column 0 of the next visible line
    always_comb begin
        disp_req_s  = 1'b0;
        disp_addr_s = {ADDR_W{1'b0}};
        if (pix_tick && pixel_x[0] && (pixel_x < X_LAST_RD) && (pixel_y[9:1] < ROW_LIMIT)) begin
            disp_req_s  = 1'b1;
            disp_addr_s = ADDR_W'(row_base(pixel_y[8:1]) + {8'd0, x_plus1_s[9:1]});
        end else if (pix_tick && (pixel_x == X_LINE_END) && (ny_s[9:1] < ROW_LIMIT)) begin
            disp_req_s  = 1'b1;
            disp_addr_s = ADDR_W'(row_base(ny_s[8:1]));
        end else begin
            disp_req_s  = 1'b0;
            disp_addr_s = {ADDR_W{1'b0}};
        end
    end

    // Fixed-priority grant plus clear/idle control state
    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        clr_color_d = clr_color_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        fifo_pop_s  = 1'b0;

        if (disp_req_s) begin
            ram_en_d   = 1'b1;
            ram_we_d   = 1'b0;
            ram_addr_d = disp_addr_s;
        end else if (state_q == ST_CLEAR) begin
            ram_en_d    = 1'b1;
            ram_we_d    = 1'b1;
            ram_addr_d  = clr_addr_q;
            ram_wdata_d = clr_color_q;
            clr_addr_d  = clr_addr_q + ADDR_W'(1);
        end else if (!fifo_empty_s) begin
            // Out-of-range host entries are consumed without touching RAM
            fifo_pop_s = 1'b1;
            if (head_addr_s <= LAST_ADDR) begin
                ram_en_d    = 1'b1;
                ram_we_d    = 1'b1;
                ram_addr_d  = head_addr_s;
                ram_wdata_d = head_data_s;
            end else begin
                ram_en_d = 1'b0;
            end
        end else begin
            ram_en_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (clear_start) begin
                    state_d     = ST_CLEAR;
                    clr_addr_d  = {ADDR_W{1'b0}};
                    clr_color_d = clear_color;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                // Leave only once the final word has actually been granted
                if (!disp_req_s && (clr_addr_q == LAST_ADDR)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pixel path: capture read data, update rgb on pixel ticks.
    // The bypass covers ticks arriving the same cycle the RAM data lands.
    always_comb begin
        rd_valid_d = ram_en_q && !ram_we_q;
        fetch_d    = fetch_q;
        rgb_d      = rgb_q;
        if (rd_valid_q) begin
            fetch_d = ram_rdata;
        end else begin
            fetch_d = fetch_q;
        end
        if (pix_tick) begin
            if (!video_on) begin
                rgb_d = {DATA_W{1'b0}};
            end else if (!pixel_x[0]) begin
                rgb_d = rd_valid_q ? ram_rdata : fetch_q;
            end else begin
                rgb_d = rgb_q;
            end
        end else begin
            rgb_d = rgb_q;
        end
    end

    // Control, RAM-port and pixel registers; reset aborts any clear at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            clr_addr_q  <= {ADDR_W{1'b0}};
            clr_color_q <= {DATA_W{1'b0}};
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= {ADDR_W{1'b0}};
            ram_wdata_q <= {DATA_W{1'b0}};
            rd_valid_q  <= 1'b0;
            fetch_q     <= {DATA_W{1'b0}};
            rgb_q       <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            clr_color_q <= clr_color_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            rd_valid_q  <= rd_valid_d;
            fetch_q     <= fetch_d;
            rgb_q       <= rgb_d;
        end
    end

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed bench for vga_vram_arbiter with a behavioural single-port RAM.
module tb_vga_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_tick;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        video_on;
    logic        host_valid;
    logic        host_ready;
    logic [16:0] host_addr;
    logic [7:0]  host_data;
    logic        clear_start;
    logic [7:0]  clear_color;
    logic        clear_busy;
    logic        ram_en;
    logic        ram_we;
    logic [16:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [7:0]  rgb;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    vga_vram_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .pix_tick    (pix_tick),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .video_on    (video_on),
        .host_valid  (host_valid),
        .host_ready  (host_ready),
        .host_addr   (host_addr),
        .host_data   (host_data),
        .clear_start (clear_start),
        .clear_color (clear_color),
        .clear_busy  (clear_busy),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .rgb         (rgb)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: one-cycle read latency, synchronous write
    logic [7:0] mem [0:76799];
    always @(posedge clk) begin
        if (ram_en && ram_we && (ram_addr < 17'd76800)) mem[ram_addr] <= ram_wdata;
        if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];
    end

    // Write monitor: 0x1F writes are clear traffic, anything else is logged
    int          clr_cnt = 0;
    int          clr_err = 0;
    logic [16:0] clr_exp = 17'd0;
    logic [24:0] wr_log [$];
    always @(negedge clk) begin
        if (!rst && ram_en && ram_we) begin
            if (ram_wdata == 8'h1F) begin
                if (ram_addr != clr_exp) clr_err <= clr_err + 1;
                clr_exp <= clr_exp + 17'd1;
                clr_cnt <= clr_cnt + 1;
            end else begin
                wr_log.push_back({ram_addr, ram_wdata});
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input int x, input int y, input logic von);
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = von;
        pix_tick = 1'b1;
        step();
        pix_tick = 1'b0;
    endtask

    int base;

    initial begin
        rst = 1'b0; pix_tick = 1'b0; pixel_x = 10'd0; pixel_y = 10'd0; video_on = 1'b0;
        host_valid = 1'b0; host_addr = 17'd0; host_data = 8'd0;
        clear_start = 1'b0; clear_color = 8'd0;
        #2 rst = 1'b1;
        #1;
        chk("rst rgb", rgb, 0);
        chk("rst ram_en", ram_en, 0);
        chk("rst ram_we", ram_we, 0);
        chk("rst ram_addr", ram_addr, 0);
        chk("rst ram_wdata", ram_wdata, 0);
        chk("rst clear_busy", clear_busy, 0);
        step(); step();
        rst = 1'b0;
        step();
        chk("post-rst host_ready", host_ready, 1);
        chk("post-rst ram_en", ram_en, 0);

        // Scan addressing
        tick(1, 0, 1'b0);   chk("scan x1y0 en", ram_en, 1); chk("scan x1y0 we", ram_we, 0); chk("scan x1y0 addr", ram_addr, 1);
        step();
        tick(799, 1, 1'b0); chk("scan x799y1 en", ram_en, 1); chk("scan x799y1 addr", ram_addr, 320);
        step();
        tick(799, 524, 1'b0); chk("scan x799y524 en", ram_en, 1); chk("scan x799y524 addr", ram_addr, 0);
        step();
        tick(639, 0, 1'b0); chk("scan x639 no read", ram_en, 0);
        step();
        tick(799, 479, 1'b0); chk("scan x799y479 no read", ram_en, 0);
        step();
        tick(5, 3, 1'b0);   chk("scan x5y3 addr", ram_addr, 323);
        step();

        // Preload word 1 through the host port
        host_valid = 1'b1; host_addr = 17'd1; host_data = 8'hA5;
        step();
        host_valid = 1'b0;
        step();
        chk("host wr en", ram_en, 1); chk("host wr we", ram_we, 1);
        chk("host wr addr", ram_addr, 1); chk("host wr data", ram_wdata, 8'hA5);
        step();

        // Pixel doubling
        tick(1, 0, 1'b1);
        step();
        tick(2, 0, 1'b1);   chk("rgb x2", rgb, 8'hA5);
        step();
        tick(3, 0, 1'b1);   chk("rgb x3", rgb, 8'hA5);
        step();
        tick(640, 0, 1'b0); chk("rgb blank x640", rgb, 0);
        step();

        // Collision: display wins, host write follows next clk
        host_valid = 1'b1; host_addr = 17'd5; host_data = 8'h3C;
        tick(1, 0, 1'b1);
        host_valid = 1'b0;
        chk("collide disp we", ram_we, 0); chk("collide disp addr", ram_addr, 1);
        step();
        chk("collide host we", ram_we, 1); chk("collide host addr", ram_addr, 5);
        chk("collide host data", ram_wdata, 8'h3C);
        step();

        // Out-of-range address dropped, last valid address written
        host_valid = 1'b1; host_addr = 17'd76800; host_data = 8'h55;
        step();
        host_valid = 1'b0;
        step();
        chk("drop oob en", ram_en, 0);
        host_valid = 1'b1; host_addr = 17'd76799; host_data = 8'h66;
        step();
        host_valid = 1'b0;
        step();
        chk("last addr we", ram_we, 1); chk("last addr", ram_addr, 76799);
        step();

        // FIFO fill against display reads every other cycle, then clear
        base = wr_log.size();
        clear_color = 8'h1F;
        for (int i = 0; i < 8; i++) begin
            pix_tick    = (i % 2 == 0);
            pixel_x     = 10'(2 * i + 11);
            pixel_y     = 10'd0;
            video_on    = 1'b1;
            host_valid  = 1'b1;
            host_addr   = 17'(200 + i);
            host_data   = 8'(8'h40 + i);
            clear_start = (i == 7);
            chk("fill host_ready", host_ready, (i == 7) ? 0 : 1);
            step();
        end
        pix_tick = 1'b0; host_valid = 1'b0; clear_start = 1'b0;
        chk("clear busy", clear_busy, 1);
        chk("clear ready low", host_ready, 0);
        repeat (50) step();
        clear_start = 1'b1; clear_color = 8'h77;
        step();
        clear_start = 1'b0;
        tick(1, 0, 1'b1);
        chk("clear disp wins we", ram_we, 0); chk("clear disp addr", ram_addr, 1);
        step();
        chk("fifo held in clear", wr_log.size() - base, 4);

        for (int k = 0; k < 80000 && clear_busy; k++) step();
        chk("clear finished", clear_busy, 0);
        chk("clear last addr", ram_addr, 76799);
        chk("clear last data", ram_wdata, 8'h1F);
        repeat (10) step();
        chk("clear write count", clr_cnt, 76800);
        chk("clear addr order errs", clr_err, 0);
        chk("fifo drained count", wr_log.size() - base, 7);
        for (int j = 0; j < 7; j++) begin
            if (base + j < wr_log.size()) begin
                chk("fifo order", wr_log[base + j], {17'(200 + j), 8'(8'h40 + j)});
            end else begin
                chk("fifo entry missing", 0, 1);
            end
        end

        // Reset mid-clear with a queued host write
        host_valid = 1'b1; host_addr = 17'd300; host_data = 8'h50;
        clear_start = 1'b1; clear_color = 8'h2E;
        step();
        host_valid = 1'b0; clear_start = 1'b0;
        chk("clear2 busy", clear_busy, 1);
        repeat (20) step();
        rst = 1'b1;
        step();
        chk("rst mid-clear en", ram_en, 0);
        chk("rst mid-clear busy", clear_busy, 0);
        chk("rst mid-clear rgb", rgb, 0);
        rst = 1'b0;
        base = wr_log.size();
        step();
        chk("rst release ready", host_ready, 1);
        repeat (10) step();
        chk("rst discards fifo", wr_log.size() - base, 0);
        chk("rst idle en", ram_en, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_vram_arbiter.md
Name: vga_vram_arbiter

Overview:
- Shares one single-port video RAM (320x240 frame buffer, 8-bit pixels, shown 2x2-doubled on 640x480) among three requesters. Priority order: display scan-out, then a frame-clear engine, then a host write port.
- Sits between vga_sync (pixel_x, pixel_y, video_on, pixel tick) and the RAM. Produces the rgb pixel byte for the DAC path.

Parameters:
- ADDR_W, 17, RAM address width (76800 words).
- DATA_W, 8, pixel width.
- FIFO_DEPTH, 4, host write FIFO entries (power of 2).
- FB_W, 320, frame-buffer width in words.
- FB_WORDS, 76800, frame-buffer size.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  asynchronous active-high reset.
- pix_tick  in  1  one-cycle pixel enable from vga_sync; at least 2 clk apart.
- pixel_x  in  10  horizontal count, 0..799.
- pixel_y  in  10  vertical count, 0..524.
- video_on  in  1  active-area flag.
- host_valid  in  1  host write request.
- host_ready  out  1  host write accepted when valid&&ready.
- host_addr  in  ADDR_W  write address.
- host_data  in  DATA_W  write data.
- clear_start  in  1  pulse: fill frame buffer with clear_color.
- clear_color  in  DATA_W  fill value, sampled on clear_start.
- clear_busy  out  1  clear in progress.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  1 = write.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  write data.
- ram_rdata  in  DATA_W  read data, valid exactly 1 clk after ram_en && !ram_we.
- rgb  out  DATA_W  pixel for the position sampled at the previous pix_tick. The top level delays hsync/vsync by one pixel tick to match.

Behaviour:
- Reset values: rgb=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, clear_busy=0, FIFO empty. host_ready=1 once reset is released.
- Display read (disp_req) is combinational, asserted on a pix_tick cycle when either:
  - pixel_x odd, pixel_x<639, pixel_y<480: addr = (pixel_y>>1)*FB_W + ((pixel_x+1)>>1).
  - pixel_x==799 and ny<480, where ny = (pixel_y==524)?0:pixel_y+1: addr = (ny>>1)*FB_W.
- Multiply-by-320 uses shift-add ((r<<8)+(r<<6)). No multiplier.
- fetch_reg loads ram_rdata one clk after a display read.
- On each pix_tick:
  - rgb <= 0 if !video_on.
  - else rgb <= fetch_reg if pixel_x even.
  - else rgb holds its value.
- Arbiter is single-cycle, registered outputs. Each clk, grant goes to exactly one requester:
  - disp_req, else
  - clear engine (if busy), else
  - FIFO head (if non-empty), else
  - idle (ram_en=0).
- Display is never stalled. A losing requester retries the next cycle; no request is dropped.
- Control FSM states:
  - IDLE: host FIFO drains. clear_start moves to CLEAR, with clr_addr=0 and the color latched.
  - CLEAR: clear_busy=1. Each non-display cycle writes clr_addr and increments it. The write at FB_WORDS-1 returns to IDLE.
  - clear_start while in CLEAR is ignored.
- Host FIFO:
  - host_ready = !full && !clear_busy.
  - In IDLE the FIFO drains (one entry per non-display cycle). During CLEAR, entries queued before clear_start stay in the FIFO.
  - Push and pop in the same cycle when full: pop happens, push is refused (ready was 0).
  - Push and pop in the same cycle when non-full: both occur and the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Host addresses >= FB_WORDS are dropped at pop: the entry is consumed, no RAM write.
- Reset mid-clear or with a non-empty FIFO: all state and the FIFO are cleared immediately (async), pending writes are discarded, clear_busy=0.

Decomposition:
- Shared package vga_pkg:
  - H_TOTAL=800, V_TOTAL=525, H_ACTIVE=640, V_ACTIVE=480, FB_W, FB_H=240, FB_WORDS, ADDR_W.
  - FSM state encoding (IDLE, CLEAR).
- Sub-module: vga_wr_fifo, a synchronous FIFO with valid/ready push, pop strobe and empty/full flags. Arbiter, address generation and FSM stay in the top.

Test Plan:
- Reset: assert rst mid-frame -> rgb=0, ram_en=0, clear_busy=0, host_ready=1 after release.
- Scan addressing: tick at (x=1, y=0) -> ram_addr=1 read. (x=799, y=1) -> addr 320. (x=799, y=524) -> addr 0. (x=639, y=0) and (x=799, y=479) -> no read.
- Pixel doubling: RAM word 1=0xA5, video_on -> rgb=0xA5 after the ticks at x=2 and x=3. x=640 -> rgb=0.
- Collision: host write (addr 5, 0x3C) valid on a disp_req cycle -> display read granted. Host write appears on the RAM the next clk; the FIFO never loses it.
- FIFO full: hold display idle and FIFO pop blocked by CLEAR, push 4 -> host_ready=0 on the 5th. After CLEAR ends, all 4 drain in order.
- Clear: clear_start with color 0x1F -> exactly 76800 writes of 0x1F, interleaved with display reads. clear_busy falls after addr 76799. A second clear_start mid-clear is ignored. rst mid-clear -> ram_en=0 next cycle.
